// File: rtl/instr_loop_sequencer.sv
// Stores a CPU-loaded instruction program and replays it iter_count times into the
// experiment FSM instruction stream. Define INSTR_SEQ_STALL_CNT_EN to build the stall counter.
module instr_loop_sequencer #(
   parameter int  PROG_DEPTH = 256,
   parameter int  INSTR_W    = 16,
   parameter int  ITER_W     = 16,
   localparam int AW         = $clog2(PROG_DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] prog_axis_tdata,
   input  logic               prog_axis_tvalid,
   output logic               prog_axis_tready,
   input  logic               prog_clear,
   input  logic               run_trig,
   input  logic [ITER_W-1:0]  iter_count,
   output logic [INSTR_W-1:0] instr_axis_tdata,
   output logic               instr_axis_tvalid,
   input  logic               instr_axis_tready,
   output logic               halt,
   output logic               fsm_run_trig,
   input  logic               fsm_run_done,
   output logic               seq_busy,
   output logic               seq_done,
   output logic               err_empty,
   output logic               prog_overflow,
   output logic [AW:0]        prog_len,
   output logic [ITER_W-1:0]  iter_idx,
   output logic [15:0]        stall_cnt
);

   typedef enum logic [2:0] {IDLE, START, PLAY, WAIT_DONE, DONE} state_t;

   state_t state, state_nxt;

   logic [INSTR_W-1:0] mem [PROG_DEPTH];
   logic               run_q;
   logic               trig_rise;
   logic               prog_full;
   logic               prog_wr;
   logic [AW-1:0]      rd_ptr;
   logic [AW-1:0]      rd_addr;
   logic [ITER_W-1:0]  iter_total;
   logic               handshake;
   logic               last_word;
   logic               last_iter;
   logic               final_beat;

   assign trig_rise  = run_trig & ~run_q;
   assign prog_full  = prog_len[AW];
   assign prog_wr    = (state == IDLE) & prog_axis_tvalid & ~prog_full & ~prog_clear;
   assign handshake  = (state == PLAY) & instr_axis_tready;
   assign last_word  = ({1'b0, rd_ptr} == prog_len - 1'b1);
   assign last_iter  = (iter_idx == iter_total - 1'b1);
   assign final_beat = handshake & last_word & last_iter;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (trig_rise) state_nxt = (prog_len == '0) ? DONE : START;
         START:     state_nxt = PLAY;
         PLAY:      if (final_beat) state_nxt = WAIT_DONE;
         WAIT_DONE: if (fsm_run_done) state_nxt = DONE;
         DONE:      if (!run_trig) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      prog_axis_tready  = (state == IDLE) & ~prog_full;
      instr_axis_tvalid = (state == PLAY);
      halt              = (state == WAIT_DONE);
      fsm_run_trig      = (state == START) | (state == PLAY) | (state == WAIT_DONE);
      seq_busy          = (state == START) | (state == PLAY) | (state == WAIT_DONE);
      seq_done          = (state == DONE);
   end

   // Read address looks one beat ahead so the next word is ready right after a handshake.
   always_comb begin
      rd_addr = rd_ptr;
      if (state == START)  rd_addr = '0;
      else if (handshake)  rd_addr = last_word ? '0 : rd_ptr + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (prog_wr) mem[prog_len[AW-1:0]] <= prog_axis_tdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q            <= 1'b0;
         rd_ptr           <= '0;
         instr_axis_tdata <= '0;
         iter_idx         <= '0;
         iter_total       <= '0;
         prog_len         <= '0;
         prog_overflow    <= 1'b0;
         err_empty        <= 1'b0;
      end else begin
         run_q  <= run_trig;
         rd_ptr <= rd_addr;
         if (state == START || state == PLAY) instr_axis_tdata <= mem[rd_addr];
         if (state == START)
            iter_idx <= '0;
         else if (handshake && last_word && !last_iter)
            iter_idx <= iter_idx + 1'b1;
         if (state == IDLE && trig_rise)
            iter_total <= (iter_count == '0) ? ITER_W'(1) : iter_count;
         if (state == IDLE && prog_clear) begin
            prog_len      <= '0;
            prog_overflow <= 1'b0;
         end else begin
            if (prog_wr) prog_len <= prog_len + 1'b1;
            if (state == IDLE && prog_axis_tvalid && prog_full) prog_overflow <= 1'b1;
         end
         if (state == IDLE && trig_rise && prog_len == '0)
            err_empty <= 1'b1;
         else if (state == DONE && !run_trig)
            err_empty <= 1'b0;
      end
   end

`ifdef INSTR_SEQ_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_q <= '0;
      else if (state == START)
         stall_q <= '0;
      else if (state == PLAY && !instr_axis_tready && stall_q != 16'hFFFF)
         stall_q <= stall_q + 16'd1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_loop_sequencer.sv
// Self-checking bench for instr_loop_sequencer: program load table, directed replays
// and randomized replays compared against a beat-list reference model.
module tb_instr_loop_sequencer;

   localparam int DEPTH = 256;
   localparam int IW    = 16;
   localparam int TW    = 16;
   localparam int AW    = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [IW-1:0] prog_axis_tdata = '0;
   logic          prog_axis_tvalid = 1'b0;
   logic          prog_axis_tready;
   logic          prog_clear = 1'b0;
   logic          run_trig = 1'b0;
   logic [TW-1:0] iter_count = '0;
   logic [IW-1:0] instr_axis_tdata;
   logic          instr_axis_tvalid;
   logic          instr_axis_tready = 1'b0;
   logic          halt;
   logic          fsm_run_trig;
   logic          fsm_run_done = 1'b0;
   logic          seq_busy;
   logic          seq_done;
   logic          err_empty;
   logic          prog_overflow;
   logic [AW:0]   prog_len;
   logic [TW-1:0] iter_idx;
   logic [15:0]   stall_cnt;

   instr_loop_sequencer #(.PROG_DEPTH(DEPTH), .INSTR_W(IW), .ITER_W(TW)) dut (
      .clk(clk), .rst(rst),
      .prog_axis_tdata(prog_axis_tdata), .prog_axis_tvalid(prog_axis_tvalid),
      .prog_axis_tready(prog_axis_tready), .prog_clear(prog_clear),
      .run_trig(run_trig), .iter_count(iter_count),
      .instr_axis_tdata(instr_axis_tdata), .instr_axis_tvalid(instr_axis_tvalid),
      .instr_axis_tready(instr_axis_tready), .halt(halt),
      .fsm_run_trig(fsm_run_trig), .fsm_run_done(fsm_run_done),
      .seq_busy(seq_busy), .seq_done(seq_done), .err_empty(err_empty),
      .prog_overflow(prog_overflow), .prog_len(prog_len),
      .iter_idx(iter_idx), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          tvalid;
      logic [IW-1:0] tdata;
      logic          clear;
      logic          exp_tready;
      int            exp_len;
      logic          exp_ovf;
   } load_vec_t;

   load_vec_t     vecs [8];
   logic [IW-1:0] prog_model [DEPTH];
   int            model_len = 0;
   int            tests = 0;
   int            failures = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input load_vec_t v);
      prog_axis_tvalid = v.tvalid;
      prog_axis_tdata  = v.tdata;
      prog_clear       = v.clear;
   endtask

   task automatic clearProgram();
      prog_clear = 1'b1;
      step();
      prog_clear = 1'b0;
      model_len  = 0;
      checkOutput("clear_len", 32'(prog_len), 0);
      checkOutput("clear_ovf", 32'(prog_overflow), 0);
   endtask

   task automatic loadWords(input int n);
      logic [IW-1:0] w;
      for (int i = 0; i < n; i++) begin
         w = IW'($urandom);
         prog_axis_tdata  = w;
         prog_axis_tvalid = 1'b1;
         step();
         prog_model[model_len] = w;
         model_len++;
      end
      prog_axis_tvalid = 1'b0;
      checkOutput("load_len", 32'(prog_len), 32'(model_len));
   endtask

   // mode 0: tready always high, 1: toggles starting high, 2: random
   task automatic runReplay(input int iters, input int mode, input bit drop_early);
      int   total;
      int   k;
      int   stalls;
      int   cyc;
      logic rdy;
      total = model_len * ((iters == 0) ? 1 : iters);
      run_trig   = 1'b0;
      iter_count = TW'(iters);
      step();
      run_trig = 1'b1;
      step();
      checkOutput("start_fsm_run_trig", 32'(fsm_run_trig), 1);
      checkOutput("start_seq_busy", 32'(seq_busy), 1);
      checkOutput("start_tvalid", 32'(instr_axis_tvalid), 0);
      checkOutput("start_prog_tready", 32'(prog_axis_tready), 0);
      iter_count = TW'($urandom);
      step();
      k = 0;
      stalls = 0;
      cyc = 0;
      while (k < total) begin
         checkOutput("play_tvalid", 32'(instr_axis_tvalid), 1);
         checkOutput("play_tdata", 32'(instr_axis_tdata), 32'(prog_model[k % model_len]));
         checkOutput("play_iter_idx", 32'(iter_idx), 32'(k / model_len));
         checkOutput("play_halt", 32'(halt), 0);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         if (cyc > 4 * total + 8) rdy = 1'b1;
         instr_axis_tready = rdy;
         if (rdy) k++;
         else     stalls++;
         if (drop_early) run_trig = 1'b0;
         cyc++;
         step();
      end
      instr_axis_tready = 1'b0;
      checkOutput("halt_after_final", 32'(halt), 1);
      checkOutput("tvalid_after_final", 32'(instr_axis_tvalid), 0);
      checkOutput("fsm_trig_wait", 32'(fsm_run_trig), 1);
`ifdef INSTR_SEQ_STALL_CNT_EN
      checkOutput("stall_cnt", 32'(stall_cnt), 32'(stalls));
`else
      checkOutput("stall_cnt", 32'(stall_cnt), 0);
`endif
      step();
      checkOutput("halt_hold", 32'(halt), 1);
      fsm_run_done = 1'b1;
      step();
      fsm_run_done = 1'b0;
      checkOutput("done_seq_done", 32'(seq_done), 1);
      checkOutput("done_halt", 32'(halt), 0);
      checkOutput("done_fsm_trig", 32'(fsm_run_trig), 0);
      checkOutput("done_busy", 32'(seq_busy), 0);
      if (!drop_early) begin
         step();
         checkOutput("done_hold", 32'(seq_done), 1);
         run_trig = 1'b0;
      end
      step();
      checkOutput("idle_seq_done", 32'(seq_done), 0);
      checkOutput("idle_err_empty", 32'(err_empty), 0);
      checkOutput("idle_prog_len", 32'(prog_len), 32'(model_len));
   endtask

   initial begin
      vecs[0] = '{1'b1, 16'h0001, 1'b0, 1'b1, 1, 1'b0};
      vecs[1] = '{1'b0, 16'h1234, 1'b0, 1'b1, 1, 1'b0};
      vecs[2] = '{1'b1, 16'h0088, 1'b0, 1'b1, 2, 1'b0};
      vecs[3] = '{1'b1, 16'hDEAD, 1'b1, 1'b1, 0, 1'b0};
      vecs[4] = '{1'b1, 16'h0001, 1'b0, 1'b1, 1, 1'b0};
      vecs[5] = '{1'b1, 16'h0088, 1'b0, 1'b1, 2, 1'b0};
      vecs[6] = '{1'b1, 16'h0005, 1'b0, 1'b1, 3, 1'b0};
      vecs[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 3, 1'b0};

      step();
      step();
      checkOutput("rst_tvalid", 32'(instr_axis_tvalid), 0);
      checkOutput("rst_tdata", 32'(instr_axis_tdata), 0);
      checkOutput("rst_flags", 32'({halt, fsm_run_trig, seq_busy, seq_done, err_empty, prog_overflow}), 0);
      checkOutput("rst_prog_len", 32'(prog_len), 0);
      checkOutput("rst_iter_idx", 32'(iter_idx), 0);
      checkOutput("rst_stall_cnt", 32'(stall_cnt), 0);
      rst = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
         step();
         checkOutput($sformatf("vec%0d_len", i), 32'(prog_len), 32'(vecs[i].exp_len));
         checkOutput($sformatf("vec%0d_tready", i), 32'(prog_axis_tready), 32'(vecs[i].exp_tready));
         checkOutput($sformatf("vec%0d_ovf", i), 32'(prog_overflow), 32'(vecs[i].exp_ovf));
      end
      prog_model[0] = 16'h0001;
      prog_model[1] = 16'h0088;
      prog_model[2] = 16'h0005;
      model_len = 3;

      runReplay(2, 0, 1'b0);
      runReplay(2, 1, 1'b0);

      clearProgram();
      loadWords(2);
      runReplay(0, 2, 1'b1);

      // Empty program: immediate error completion without a run trigger
      clearProgram();
      run_trig = 1'b1;
      step();
      checkOutput("empty_fsm_trig0", 32'(fsm_run_trig), 0);
      step();
      checkOutput("empty_seq_done", 32'(seq_done), 1);
      checkOutput("empty_err", 32'(err_empty), 1);
      checkOutput("empty_fsm_trig1", 32'(fsm_run_trig), 0);
      run_trig = 1'b0;
      step();
      checkOutput("empty_idle_done", 32'(seq_done), 0);
      checkOutput("empty_idle_err", 32'(err_empty), 0);

      // Full program, overflow beat, full-depth replay, then clear
      loadWords(DEPTH);
      checkOutput("full_tready", 32'(prog_axis_tready), 0);
      checkOutput("full_ovf0", 32'(prog_overflow), 0);
      prog_axis_tdata  = 16'hBEEF;
      prog_axis_tvalid = 1'b1;
      step();
      prog_axis_tvalid = 1'b0;
      checkOutput("ovf_flag", 32'(prog_overflow), 1);
      checkOutput("ovf_len", 32'(prog_len), DEPTH);
      checkOutput("ovf_tready", 32'(prog_axis_tready), 0);
      runReplay(1, 2, 1'b0);
      clearProgram();
      checkOutput("cleared_tready", 32'(prog_axis_tready), 1);

      for (int r = 0; r < 10; r++) begin
         clearProgram();
         loadWords(int'($urandom_range(1, 8)));
         runReplay(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a replay
      clearProgram();
      loadWords(3);
      iter_count = 16'd5;
      run_trig = 1'b1;
      step();
      step();
      instr_axis_tready = 1'b1;
      step();
      step();
      #2 rst = 1'b0;
      #1;
      checkOutput("midrst_tvalid", 32'(instr_axis_tvalid), 0);
      checkOutput("midrst_flags", 32'({halt, fsm_run_trig, seq_busy, seq_done, err_empty, prog_overflow}), 0);
      checkOutput("midrst_len", 32'(prog_len), 0);
      checkOutput("midrst_iter_idx", 32'(iter_idx), 0);
      checkOutput("midrst_tdata", 32'(instr_axis_tdata), 0);
      instr_axis_tready = 1'b0;
      run_trig = 1'b0;
      step();
      checkOutput("midrst_held_busy", 32'(seq_busy), 0);
      rst = 1'b1;
      model_len = 0;
      step();
      run_trig = 1'b1;
      step();
      step();
      checkOutput("postrst_err_empty", 32'(err_empty), 1);
      checkOutput("postrst_seq_done", 32'(seq_done), 1);
      checkOutput("postrst_fsm_trig", 32'(fsm_run_trig), 0);
      run_trig = 1'b0;
      step();
      checkOutput("postrst_idle", 32'(seq_done), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/instr_loop_sequencer.md
# instr_loop_sequencer

Program store and replay engine for the experiment instruction stream. The CPU loads a program of instruction words once; on a run trigger the block replays it a configured number of iterations into the experiment FSM's instruction AXI-Stream, drives that FSM's run trigger, and asserts halt after the last word. It sits between the CPU-side instruction bus and `experiment_fsm`, replacing direct CPU streaming so that long annealing loops run without host involvement.

## Interface
- `PROG_DEPTH`, 256: instruction words stored; power of two, ≥2. `AW = $clog2(PROG_DEPTH)`.
- `INSTR_W`, 16: instruction word width.
- `ITER_W`, 16: iteration counter width.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock.
- `rst` in 1: async active-low reset.
- `prog_axis_tdata` in INSTR_W: program word from CPU.
- `prog_axis_tvalid` in 1 / `prog_axis_tready` out 1: program load handshake.
- `prog_clear` in 1: pulse, sets program length to 0 (IDLE only).
- `run_trig` in 1: level; rising edge starts replay.
- `iter_count` in ITER_W: iterations; sampled at start.
- `instr_axis_tdata` out INSTR_W / `instr_axis_tvalid` out 1 / `instr_axis_tready` in 1: stream to experiment FSM.
- `halt` out 1: program exhausted, to experiment FSM.
- `fsm_run_trig` out 1: run trigger to experiment FSM.
- `fsm_run_done` in 1: done flag from experiment FSM.
- `seq_busy` out 1, `seq_done` out 1, `err_empty` out 1, `prog_overflow` out 1.
- `prog_len` out AW+1: words loaded.
- `iter_idx` out ITER_W: current iteration, 0-based.
- `stall_cnt` out 16: see Configuration.

## Operation
- States: IDLE, START, PLAY, WAIT_DONE, DONE.
- IDLE: `prog_axis_tready = (prog_len < PROG_DEPTH)`; each accepted beat writes `mem[prog_len]`, `prog_len++`. Beat offered when full: dropped, `prog_overflow` set (sticky until `prog_clear` or reset). `prog_clear` clears `prog_len` and `prog_overflow`; if coincident with a write beat, clear wins and the beat is dropped.
- IDLE → START on `run_trig` rising edge (0→1 between consecutive cycles). `iter_count` latched; 0 treated as 1. If `prog_len == 0`: go straight to DONE with `err_empty = 1`, no `fsm_run_trig`.
- START: `fsm_run_trig = 1`, read pointer = 0, `iter_idx = 0`, prefetch `mem[0]`; → PLAY.
- PLAY: present `mem[rd_ptr]`. On handshake (`tvalid & tready`): if `rd_ptr == prog_len-1`, wrap `rd_ptr` to 0 and increment `iter_idx`, else `rd_ptr++`. Final beat (last word, last iteration): drop `tvalid`, assert `halt`, → WAIT_DONE.
- WAIT_DONE: hold `halt = 1`, `fsm_run_trig = 1` until `fsm_run_done = 1`; then drop both → DONE.
- DONE: `seq_done = 1` until `run_trig` is low, then → IDLE and clear `seq_done`, `err_empty`.
- `seq_busy = 1` in START, PLAY, WAIT_DONE.
- `prog_axis_tready = 0` outside IDLE; program is immutable during replay.
- `run_trig` falling during PLAY/WAIT_DONE is ignored; replay always completes.

## Timing
- Reset values: all outputs 0 (`instr_axis_tdata`, `prog_len`, `iter_idx`, `stall_cnt`, flags). State IDLE. Memory contents are not reset.
- Memory read is synchronous, one cycle. First `instr_axis_tvalid` is asserted 2 cycles after the cycle `run_trig` is sampled high; `fsm_run_trig` is asserted 1 cycle after that sample.
- Throughput: one word per cycle while `tready = 1`, including across iteration wrap (no bubble).
- `tdata` is stable while `tvalid & !tready`. `tvalid` never drops without a handshake.
- `halt` rises in the cycle after the final handshake, with `tvalid = 0` in that same cycle.
- Total beats delivered = `prog_len × max(iter_count,1)`; `iter_idx` wraps to 0 only via reset or the next start.
- Reset mid-replay: immediate return to IDLE with all outputs 0. `prog_len` returns to 0, so the program must be reloaded.

## Configuration
- `INSTR_SEQ_STALL_CNT_EN` defined: `stall_cnt` counts cycles in PLAY with `tvalid & !tready`, saturating at 0xFFFF, and clears on each start.
- Not defined: `stall_cnt` is tied to 0 and no counter logic is built.

## Test plan
- Load 3 words (0x0001, 0x0088, 0x0005), `iter_count = 2`, `tready = 1` → beats 0x0001,0x0088,0x0005,0x0001,0x0088,0x0005 on consecutive cycles; `halt` follows; `fsm_run_done` pulse → `seq_done = 1`.
- Same program with `tready` toggling 1/0 each cycle → identical 6-beat sequence; `tdata` held through stalls; with macro, `stall_cnt = 5` (one stall cycle between each pair of consecutive beats).
- Load 256 words, then a 257th beat → `prog_axis_tready = 0`, `prog_overflow = 1`, `prog_len = 256`; `prog_clear` → `prog_len = 0`, flag cleared.
- `prog_len = 0`, raise `run_trig` → `seq_done = 1` and `err_empty = 1` within 2 cycles; `fsm_run_trig` never asserted; drop `run_trig` → back to IDLE.
- `iter_count = 0`, 2-word program → exactly 2 beats, then `halt`.
- Reset asserted during PLAY → all outputs 0 next edge; `prog_len = 0`; later `run_trig` gives `err_empty = 1`.
